blink_meter: RTL and testbench

Receive-side companion to the LED toggle generator: samples an asynchronous toggling line, measures the number of clock cycles between successive toggles (half-period), and reports when the line blinks steadily at the expected rate. It is used in self-checking loopback setups, driven by a blinker's `led` output or an external pin, and provides sample, lock and stuck status to test logic.

---
 rtl/blink_meter_pkg.sv | 22 ++
 rtl/toggle_edge_sync.sv | 65 ++++++
 rtl/blink_meter.sv | 136 +++++++++++++
 tb/tb_blink_meter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_meter_pkg
// Description : Shared types and constants for the blink_meter receiver.
//               The state enum is used by the top-level FSM, and the
//               synchronizer depth by toggle_edge_sync.
// Revision    : 1.0 - initial release
// ============================================================================
package blink_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } meter_state_t;

  // Number of flops in the metastability synchronizer on led_in
  localparam int SYNC_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/toggle_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : toggle_edge_sync
// Description : Brings the asynchronous led_in into the clk domain and flags
//               every transition, rising or falling, as a one-cycle edge_det.
//               Optional macro BLINK_METER_GLITCH_FILTER_EN adds a stability
//               stage that ignores pulses shorter than 2 cycles, at the cost
//               of one extra cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_edge_sync
  import blink_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic led_in,
  output logic edge_det
);

  logic [SYNC_DEPTH-1:0] sync_chain;
  logic                  sync_level;

  // Metastability synchronizer; led_in enters at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_chain <= '0;
    else     sync_chain <= {sync_chain[SYNC_DEPTH-2:0], led_in};
  end

  assign sync_level = sync_chain[SYNC_DEPTH-1];

`ifdef BLINK_METER_GLITCH_FILTER_EN
  logic stable_q;
  logic filt_level;
  logic settled;

  // Level is trusted only once it has matched over two consecutive samples
  assign settled = (sync_level == stable_q);

  // One-cycle history of the synchronized level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= 1'b0;
    else     stable_q <= sync_level;
  end

  // Filtered level; doubles as the previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          filt_level <= 1'b0;
    else if (settled) filt_level <= stable_q;
  end

  assign edge_det = settled && (stable_q != filt_level);
`else
  logic prev_level;

  // Previous synchronized level for edge comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_level <= 1'b0;
    else     prev_level <= sync_level;
  end

  assign edge_det = (sync_level != prev_level);
`endif

endmodule
`default_nettype wire

// File: rtl/blink_meter.sv
`default_nettype none
// ============================================================================
// Module      : blink_meter
// Description : Measures the half-period of a toggling line and reports a
//               sample per edge, steady-rate lock and stuck-line status.
//               Optional macro BLINK_METER_GLITCH_FILTER_EN enables the
//               glitch filter inside toggle_edge_sync.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_meter
  import blink_meter_pkg::*;
#(
  parameter int N          = 24,
  parameter int CNT_W      = 16,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 4 * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  output logic [CNT_W-1:0] half_period,
  output logic             sample_valid,
  output logic             locked,
  output logic             stuck
);

  localparam int               MATCH_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W:0]   N_EXT       = (CNT_W+1)'(N);
  localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_MAX  = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  meter_state_t       state, state_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   sample;
  logic [CNT_W:0]     sample_ext;
  logic [CNT_W:0]     diff;
  logic               is_match;
  logic               edge_det;
  logic               timeout_hit;
  logic               take_sample;

  toggle_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .edge_det (edge_det)
  );

  // Cycles between edges: the count before the edge plus the edge cycle itself
  assign sample     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign sample_ext = {1'b0, sample};
  // One extra bit keeps the absolute difference from wrapping
  assign diff       = (sample_ext >= N_EXT) ? (sample_ext - N_EXT) : (N_EXT - sample_ext);
  assign is_match   = (diff <= TOL_EXT);
  // An edge in the same cycle takes precedence over the timeout
  assign timeout_hit = !edge_det && (cnt == TIMEOUT_PRE);

  // Saturating cycle counter, cleared by each edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (edge_det)       cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
  end

  // FSM state and consecutive-match counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  // Next-state, match tracking and sample decision
  always_comb begin
    state_nxt   = state;
    match_nxt   = match_cnt;
    take_sample = 1'b0;
    if (edge_det) begin
      case (state)
        IDLE: begin
          state_nxt = MEASURE;
        end
        MEASURE: begin
          take_sample = 1'b1;
          if (is_match) begin
            match_nxt = (match_cnt == LOCK_MAX) ? LOCK_MAX : match_cnt + MATCH_ONE;
            if (match_nxt == LOCK_MAX) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          take_sample = 1'b1;
          if (!is_match) begin
            match_nxt = '0;
            state_nxt = MEASURE;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end
  end

  // Registered outputs: sample strobe/value, lock decode and stuck flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_period  <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      sample_valid <= take_sample;
      if (take_sample) half_period <= sample;
      locked <= (state_nxt == LOCKED);
      if (edge_det)         stuck <= 1'b0;
      else if (timeout_hit) stuck <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blink_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_meter
// Description : Self-checking bench for blink_meter (N=4, CNT_W=8, TOL=1,
//               LOCK_COUNT=4, TIMEOUT=16). Honors BLINK_METER_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_meter;

  localparam int N          = 4;
  localparam int CNT_W      = 8;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 16;
`ifdef BLINK_METER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 2;
`endif
  localparam int LOG_SZ = 16384;
  localparam int NVEC   = 19;

  logic             clk;
  logic             rst;
  logic             led_in;
  logic [CNT_W-1:0] half_period;
  logic             sample_valid;
  logic             locked;
  logic             stuck;

  blink_meter #(
    .N(N), .CNT_W(CNT_W), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .led_in       (led_in),
    .half_period  (half_period),
    .sample_valid (sample_valid),
    .locked       (locked),
    .stuck        (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gp    = 0;

  logic             log_valid  [LOG_SZ];
  logic [CNT_W-1:0] log_hp     [LOG_SZ];
  logic             log_locked [LOG_SZ];
  logic             log_stuck  [LOG_SZ];

  // Reference model: works on sampled input levels and elapsed cycle counts
  bit   model_on;
  int   mp, m_last, m_run, m_hp;
  bit   m_wait, m_stuck, m_locked;
  logic h_prev;
  logic flt_h [4];

  typedef struct {
    int gap;
    bit exp_valid;
    int exp_hp;
    bit exp_locked;
  } vec_t;

  vec_t tbl    [NVEC];
  int   tog_gp [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, gp);
    end
  endtask

  task automatic model_reset();
    mp = 0; m_last = 0; m_run = 0; m_hp = 0;
    m_wait = 1'b1; m_stuck = 1'b0; m_locked = 1'b0;
    h_prev = 1'b0;
    for (int i = 0; i < 4; i++) flt_h[i] = 1'b0;
  endtask

  // Drive level v for one cycle, advance one clock, log and check outputs
  task automatic step(input logic v);
    logic h, fnow, ev;
    int   gap, s, d;
    bit   e_valid;
    @(negedge clk);
    led_in = v;
    @(posedge clk);
    gp++;
    e_valid = 1'b0;
    if (model_on) begin
      mp++;
      h    = led_in;
      fnow = (!FILT || h == h_prev) ? h : flt_h[0];
      flt_h[3] = flt_h[2]; flt_h[2] = flt_h[1]; flt_h[1] = flt_h[0]; flt_h[0] = fnow;
      h_prev = h;
      ev  = (flt_h[2] != flt_h[3]);
      gap = mp - m_last;
      if (ev) begin
        m_stuck = 1'b0;
        m_last  = mp;
        if (m_wait) begin
          m_wait = 1'b0;
        end else begin
          s = (gap > 255) ? 255 : gap;
          m_hp = s;
          e_valid = 1'b1;
          d = (s > N) ? s - N : N - s;
          if (d <= TOL) m_run++;
          else          m_run = 0;
          m_locked = (m_run >= LOCK_COUNT);
        end
      end else if (gap == TIMEOUT) begin
        m_stuck = 1'b1; m_wait = 1'b1; m_run = 0; m_locked = 1'b0;
      end
    end
    #1;
    log_valid[gp]  = sample_valid;
    log_hp[gp]     = half_period;
    log_locked[gp] = locked;
    log_stuck[gp]  = stuck;
    if (model_on) begin
      check("mdl_valid",  32'(sample_valid), 32'(e_valid));
      check("mdl_hp",     32'(half_period),  32'(m_hp));
      check("mdl_locked", 32'(locked),       32'(m_locked));
      check("mdl_stuck",  32'(stuck),        32'(m_stuck));
    end
  endtask

  initial begin
    logic lvl;
    int   q, g, n, cnt_v;

    tbl[0]  = '{4,  1'b0, 0, 1'b0};
    tbl[1]  = '{4,  1'b1, 4, 1'b0};
    tbl[2]  = '{4,  1'b1, 4, 1'b0};
    tbl[3]  = '{4,  1'b1, 4, 1'b0};
    tbl[4]  = '{7,  1'b1, 4, 1'b1};
    tbl[5]  = '{5,  1'b1, 7, 1'b0};
    tbl[6]  = '{4,  1'b1, 5, 1'b0};
    tbl[7]  = '{3,  1'b1, 4, 1'b0};
    tbl[8]  = '{4,  1'b1, 3, 1'b0};
    tbl[9]  = '{5,  1'b1, 4, 1'b1};
    tbl[10] = '{3,  1'b1, 5, 1'b1};
    tbl[11] = '{4,  1'b1, 3, 1'b1};
    tbl[12] = '{20, 1'b1, 4, 1'b1};
    tbl[13] = '{4,  1'b0, 4, 1'b0};
    tbl[14] = '{4,  1'b1, 4, 1'b0};
    tbl[15] = '{4,  1'b1, 4, 1'b0};
    tbl[16] = '{4,  1'b1, 4, 1'b0};
    tbl[17] = '{4,  1'b1, 4, 1'b1};
    tbl[18] = '{4,  1'b1, 4, 1'b1};

    // Reset held with clocks running
    model_on = 1'b0;
    model_reset();
    led_in = 1'b0;
    rst    = 1'b0;
    #1 rst = 1'b1;
    lvl = 1'b0;
    repeat (3) step(lvl);
    check("rst_hp",     32'(half_period),  0);
    check("rst_valid",  32'(sample_valid), 0);
    check("rst_locked", 32'(locked),       0);
    check("rst_stuck",  32'(stuck),        0);
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;
    repeat (3) step(lvl);

    // Table: steady blinking, rate changes, timeout and relock
    for (int i = 0; i < NVEC; i++) begin
      lvl = ~lvl;
      step(lvl);
      tog_gp[i] = gp;
      for (int k = 1; k < tbl[i].gap; k++) step(lvl);
    end
    for (int i = 0; i < NVEC; i++) begin
      q = tog_gp[i] + LAT;
      check($sformatf("tbl%0d_valid", i),  32'(log_valid[q]),  32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_hp", i),     32'(log_hp[q]),     32'(tbl[i].exp_hp));
      check($sformatf("tbl%0d_locked", i), 32'(log_locked[q]), 32'(tbl[i].exp_locked));
    end

    // Stuck timing around the long gap after entry 12
    q = tog_gp[12] + LAT;
    check("stuck_before",  32'(log_stuck[q + 15]),  0);
    check("stuck_rise",    32'(log_stuck[q + 16]),  1);
    check("locked_before", 32'(log_locked[q + 15]), 1);
    check("locked_drop",   32'(log_locked[q + 16]), 0);
    q = tog_gp[13] + LAT;
    check("stuck_held",    32'(log_stuck[q - 1]),   1);
    check("stuck_clear",   32'(log_stuck[q]),       0);

    // One-cycle glitch two cycles after a real toggle
    lvl = ~lvl;
    step(lvl);
    g = gp;
    step(lvl);
    step(~lvl);
    step(lvl);
    lvl = ~lvl;
    repeat (4) step(lvl);
`ifdef BLINK_METER_GLITCH_FILTER_EN
    cnt_v = 0;
    for (int k = g + LAT + 1; k < g + 4 + LAT; k++) cnt_v += int'(log_valid[k]);
    check("glitch_nosample", 32'(cnt_v), 0);
    check("glitch_real_hp",  32'(log_hp[g + 4 + LAT]),     4);
    check("glitch_locked",   32'(log_locked[g + 4 + LAT]), 1);
`else
    cnt_v = int'(log_valid[g + 3 + LAT]) + int'(log_valid[g + 4 + LAT]);
    check("glitch_nvalid",   32'(cnt_v), 2);
    check("glitch_hp_a",     32'(log_hp[g + 3 + LAT]),     1);
    check("glitch_hp_b",     32'(log_hp[g + 4 + LAT]),     1);
    check("glitch_locked",   32'(log_locked[g + 4 + LAT]), 0);
`endif

    // Relock, then assert reset between clock edges
    for (int i = 0; i < 5; i++) begin
      lvl = ~lvl;
      step(lvl);
      repeat (3) step(lvl);
    end
    check("pre_arst_locked", 32'(locked),      1);
    check("pre_arst_hp",     32'(half_period), 4);
    #3 rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked),       0);
    check("arst_hp",     32'(half_period),  0);
    check("arst_stuck",  32'(stuck),        0);
    check("arst_valid",  32'(sample_valid), 0);
    model_on = 1'b0;
    repeat (2) step(lvl);
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;

    // Randomized toggle intervals against the reference model
    for (int i = 0; i < 250; i++) begin
      lvl = ~lvl;
      step(lvl);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 20);
      else                          n = $urandom_range(3, 5);
      for (int k = 1; k < n; k++) step(lvl);
    end
    repeat (20) step(lvl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
